output_arbiter: RTL and testbench
=================================

# output_arbiter

Per-output-port switch allocator for the 5-port router. It collects the 5-bit request vectors from the input ports (bit i of this block's `request` is bit k of input port i's request vector, where k is this output's index). It grants the output to one input at a time using round-robin priority and holds the grant for a whole packet. While the grant is held it sequences the serial flit transfer: it drives the crossbar select and the downstream FIFO write enable, and returns per-input stall.

## Interface
- `packet_size`, 32: bits per packet including the 16-bit address header.
- `flit_size`, 4: bits per flit.
- `flits_per_packet`, derived as `packet_size/flit_size` (default 8). `packet_size` must be an integer multiple of `flit_size`, and the quotient must be ≥ 1.

- `clk` input 1: clock. All state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `request` input 5: bit i set means input port i wants this output.
- `src_empty` input 5: bit i set means input port i's FIFO has no flit this cycle.
- `downstream_full` input 1: the next-hop FIFO cannot accept a flit this cycle.
- `grant` output 5: one-hot registered grant, or zero when idle.
- `grant_valid` output 1: OR of `grant`.
- `mux_select` output 3: binary index (0–4) of the granted input, driving the crossbar.
- `write_fifo` output 1: a flit is transferred downstream this cycle.
- `stall_out` output 5: bit i set means input port i must hold its flit.
- `packet_done` output 1: one-cycle pulse on the cycle the last flit of a packet is written.

## Operation
- States: IDLE and BUSY.
- Round-robin pointer `ptr` (0–4) holds the highest-priority index. Arbitration searches `ptr`, `ptr+1`, … modulo 5, and the first set `request` bit wins.
- IDLE:
  - If `request` is nonzero: register the winner into `grant` and `mux_select`, load the flit counter with `flits_per_packet`, and move to BUSY.
  - Otherwise stay in IDLE with `grant` = 0.
- BUSY:
  - `write_fifo` = `~downstream_full & ~src_empty[mux_select]`.
  - On each write, the counter decrements by 1.
  - A write while the counter equals 1 is the last flit. It asserts `packet_done`, clears `grant`, sets `ptr` to (winner+1) mod 5, and returns to IDLE.
- The grant is committed for the whole packet. Deassertion of the winner's `request` during BUSY is ignored, and the counter still requires `flits_per_packet` writes.
- `stall_out[i]`:
  - For a non-winning i: `request[i] & ~grant[i]`.
  - For the winner: `~write_fifo`.
- Only the winner's `src_empty` bit is examined; other bits are ignored.
- The counter width is ceil(log2(`flits_per_packet`+1)). It never underflows, because it is only decremented on a write while BUSY.

## Timing
- Reset values: `grant` = 0, `grant_valid` = 0, `mux_select` = 0, `write_fifo` = 0, `packet_done` = 0, `ptr` = 0, counter = 0, state IDLE. While `reset` is high, `stall_out` = `request`.
- Reset asserted mid-packet aborts the transfer immediately. No further `write_fifo` is issued, and the partial packet is not completed.
- Grant latency: a request sampled in IDLE at edge N gives `grant` visible in cycle N+1. The first `write_fifo` can occur in cycle N+1.
- Minimum packet duration is `flits_per_packet` cycles. Each cycle with `downstream_full` = 1 or the winner's `src_empty` = 1 adds one cycle.
- Last write in cycle M: `packet_done` is high in cycle M only, and the state is IDLE in cycle M+1. Without the macro below, the next grant is visible at the earliest in cycle M+2 (one bubble cycle).
- Simultaneous requests are resolved by `ptr` only; request arrival order is irrelevant.
- A single persistent requester is re-granted each packet, with a bubble between packets when the macro is off.

## Configuration
- `ARB_BACK_TO_BACK_EN` defined:
  - In the cycle of the last write, the arbiter evaluates `request` using the updated pointer (winner+1) and, if any bit is set, loads the new `grant` and counter and stays in BUSY.
  - The next packet's first write can occur in cycle M+1, so there is no bubble.
  - `packet_done` still pulses in cycle M.
- Undefined: the behaviour is as described above, with a mandatory IDLE cycle between packets.

## Test plan
- **Single requester:** `request` = 5'b00100 from cycle 1, with `src_empty` and `downstream_full` low. Expect:
  - `grant` = 5'b00100 and `mux_select` = 2 in cycle 2;
  - `write_fifo` high in cycles 2–9;
  - `packet_done` in cycle 9 and `grant` = 0 in cycle 10;
  - `stall_out` = 0 throughout BUSY.
- **Full contention:** `request` = 5'b11111 held high. Grants occur in the order 0, 1, 2, 3, 4, 0. Each packet gives exactly 8 writes, and each non-winner has its stall bit set.
- **Backpressure:** `downstream_full` high for 3 cycles after the 4th write. Expect `write_fifo` low and the winner's `stall_out` high for those cycles, exactly 8 writes in total, and `packet_done` 3 cycles later than nominal.
- **Source empty:** the winner's `src_empty` is pulsed for 2 cycles, and a non-winner's `src_empty` toggles throughout. Only the winner's pulse stretches the packet, by 2 cycles.
- **Reset mid-packet:** assert `reset` after the 5th write. In the same cycle `grant`, `write_fifo` and `ptr` go to 0. After release with `request` = 5'b10001, port 0 is granted.
- **Back-to-back:** repeat the full-contention scenario with `ARB_BACK_TO_BACK_EN` defined. The first write of the next packet occurs in the cycle immediately after `packet_done`, and 5 packets complete in 40 cycles.

Source files
------------

// File: rtl/output_arbiter.sv
// Per-output round-robin switch allocator: holds a grant for a whole packet and paces serial flit writes.
// Optional ARB_BACK_TO_BACK_EN: re-arbitrate on the last flit so consecutive packets need no idle cycle.
module output_arbiter #(
  parameter int packet_size = 32,
  parameter int flit_size   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] request,
  input  logic [4:0] src_empty,
  input  logic       downstream_full,
  output logic [4:0] grant,
  output logic       grant_valid,
  output logic [2:0] mux_select,
  output logic       write_fifo,
  output logic [4:0] stall_out,
  output logic       packet_done
);

  localparam int flits_per_packet = packet_size / flit_size;
  localparam int cw = $clog2(flits_per_packet + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state, state_next;
  logic [4:0]     grant_next;
  logic [2:0]     mux_next;
  logic [2:0]     ptr, ptr_next;
  logic [cw-1:0]  count, count_next;
  logic           last_flit;
  logic [3:0]     idle_pick;

  function automatic logic [2:0] wrap_inc(input logic [2:0] v);
    return (v == 3'd4) ? 3'd0 : v + 3'd1;
  endfunction

  // Returns {found, index} of the first set request bit at or after base, modulo 5.
  function automatic logic [3:0] pick(input logic [4:0] req, input logic [2:0] base);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'd0;
    idx = base;
    for (int k = 0; k < 5; k++) begin
      if (!res[3] && req[idx])
        res = {1'b1, idx};
      idx = wrap_inc(idx);
    end
    return res;
  endfunction

  assign idle_pick   = pick(request, ptr);
  assign write_fifo  = (state == BUSY) && !downstream_full && !src_empty[mux_select];
  assign last_flit   = write_fifo && (count == cw'(1));
  assign packet_done = last_flit;
  assign grant_valid = |grant;

  // grant is zero during reset and idle, so every stall bit then mirrors request.
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_stall
      assign stall_out[gi] = grant[gi] ? ~write_fifo : request[gi];
    end
  endgenerate

`ifdef ARB_BACK_TO_BACK_EN
  logic [3:0] next_pick;
  assign next_pick = pick(request, wrap_inc(mux_select));
`endif

  always_comb begin
    state_next = state;
    grant_next = grant;
    mux_next   = mux_select;
    ptr_next   = ptr;
    count_next = count;
    case (state)
      IDLE: begin
        if (idle_pick[3]) begin
          grant_next = 5'b00001 << idle_pick[2:0];
          mux_next   = idle_pick[2:0];
          count_next = cw'(flits_per_packet);
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (write_fifo) begin
          count_next = count - cw'(1);
          if (last_flit) begin
            ptr_next   = wrap_inc(mux_select);
            grant_next = 5'b00000;
            state_next = IDLE;
`ifdef ARB_BACK_TO_BACK_EN
            if (next_pick[3]) begin
              grant_next = 5'b00001 << next_pick[2:0];
              mux_next   = next_pick[2:0];
              count_next = cw'(flits_per_packet);
              state_next = BUSY;
            end
`endif
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 5'b00000;
      mux_select <= 3'd0;
      ptr        <= 3'd0;
      count      <= '0;
    end else begin
      state      <= state_next;
      grant      <= grant_next;
      mux_select <= mux_next;
      ptr        <= ptr_next;
      count      <= count_next;
    end
  end

endmodule

// File: tb/tb_output_arbiter.sv
// Bench for output_arbiter: vector table, scenario sequences and randomized traffic vs. an integer reference model.
module tb_output_arbiter;

  localparam int FPP = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] request = '0;
  logic [4:0] src_empty = '0;
  logic       downstream_full = 1'b0;
  logic [4:0] grant;
  logic       grant_valid;
  logic [2:0] mux_select;
  logic       write_fifo;
  logic [4:0] stall_out;
  logic       packet_done;

  output_arbiter dut (
    .clk(clk), .reset(reset), .request(request), .src_empty(src_empty),
    .downstream_full(downstream_full), .grant(grant), .grant_valid(grant_valid),
    .mux_select(mux_select), .write_fifo(write_fifo), .stall_out(stall_out),
    .packet_done(packet_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  // Reference model: winner index (-1 when idle), flits still owed, round-robin start.
  int m_win = -1;
  int m_left = 0;
  int m_ptr = 0;

  logic [4:0] last_grant, last_stall;
  logic [2:0] last_mux;
  logic       last_write, last_done, last_gv;

  function automatic int first_from(input logic [4:0] rq, input int base);
    for (int k = 0; k < 5; k++)
      if (rq[(base + k) % 5]) return (base + k) % 5;
    return -1;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got %0d, want %0d", name, cyc, got, want);
    end
  endtask

  task automatic step(input logic [4:0] rq, input logic [4:0] se, input logic df, input string tag);
    logic [4:0] e_grant, e_stall;
    logic       e_write, e_done;
    bit         ok;
    request = rq; src_empty = se; downstream_full = df;
    #1;
    e_grant = (m_win >= 0) ? 5'(1 << m_win) : 5'b0;
    e_write = (m_win >= 0) && !df && !se[m_win];
    e_done  = e_write && (m_left == 1);
    for (int i = 0; i < 5; i++)
      e_stall[i] = (i == m_win) ? !e_write : rq[i];
    last_grant = grant; last_stall = stall_out; last_mux = mux_select;
    last_write = write_fifo; last_done = packet_done; last_gv = grant_valid;
    ok = (grant == e_grant) && (grant_valid == (m_win >= 0)) && (write_fifo == e_write) &&
         (packet_done == e_done) && (stall_out == e_stall) &&
         ((m_win < 0) || (mux_select == 3'(m_win)));
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got grant=%b gv=%b mux=%0d wr=%b done=%b stall=%b, want grant=%b mux=%0d wr=%b done=%b stall=%b",
               tag, cyc, grant, grant_valid, mux_select, write_fifo, packet_done, stall_out,
               e_grant, m_win, e_write, e_done, e_stall);
    end
    @(posedge clk);
    if (m_win < 0) begin
      if (rq != 0) begin m_win = first_from(rq, m_ptr); m_left = FPP; end
    end else if (e_write) begin
      m_left--;
      if (m_left == 0) begin
        m_ptr = (m_win + 1) % 5;
        m_win = -1;
`ifdef ARB_BACK_TO_BACK_EN
        if (rq != 0) begin m_win = first_from(rq, m_ptr); m_left = FPP; end
`endif
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; request = 5'b10101; src_empty = '0; downstream_full = 1'b0;
    #1;
    chk("rst_grant", int'(grant), 0);
    chk("rst_write", int'(write_fifo), 0);
    chk("rst_done_gv", int'({packet_done, grant_valid}), 0);
    chk("rst_stall", int'(stall_out), 5'b10101);
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    m_win = -1; m_left = 0; m_ptr = 0;
  endtask

  function automatic int onehot_idx(input logic [4:0] v);
    for (int i = 0; i < 5; i++) if (v[i]) return i;
    return -1;
  endfunction

  typedef struct {
    logic [4:0] req; logic [4:0] se; logic df;
    logic [4:0] g; logic [2:0] mux; logic wr; logic dn; logic [4:0] st;
  } vec_t;
  vec_t tbl[10];

  initial begin
    int wr, bp, done_at, ndone, wcount, first_write, fifth_done;
    int wins[$];
    int pkt_writes[$];
    logic df;

    // Single requester on port 2; deassertion on the last flit must be ignored.
    tbl[0] = '{5'b00100, 5'b00000, 1'b0, 5'b00000, 3'd0, 1'b0, 1'b0, 5'b00100};
    for (int k = 1; k <= 8; k++)
      tbl[k] = '{5'b00100, 5'b00000, 1'b0, 5'b00100, 3'd2, 1'b1, 1'b0, 5'b00000};
    tbl[3].se = 5'b11011;
    tbl[8].req = 5'b00000;
    tbl[8].dn = 1'b1;
    tbl[9] = '{5'b00000, 5'b00000, 1'b0, 5'b00000, 3'd0, 1'b0, 1'b0, 5'b00000};

    @(negedge clk);
    do_reset();
    for (int k = 0; k < 10; k++) begin
      step(tbl[k].req, tbl[k].se, tbl[k].df, "table");
      n_vec++;
      if (last_grant != tbl[k].g || last_write != tbl[k].wr || last_done != tbl[k].dn ||
          last_stall != tbl[k].st || last_gv != (|tbl[k].g) ||
          (tbl[k].g != 0 && last_mux != tbl[k].mux)) begin
        n_bad++;
        $display("FAIL table[%0d]: got grant=%b mux=%0d wr=%b done=%b stall=%b, want grant=%b mux=%0d wr=%b done=%b stall=%b",
                 k, last_grant, last_mux, last_write, last_done, last_stall,
                 tbl[k].g, tbl[k].mux, tbl[k].wr, tbl[k].dn, tbl[k].st);
      end
    end

    // Full contention: order 0..4,0 and 8 writes per packet.
    do_reset();
    ndone = 0; wcount = 0; first_write = -1; fifth_done = -1;
    for (int c = 0; c < 200 && ndone < 6; c++) begin
      step(5'b11111, 5'b00000, 1'b0, "contention");
      if (last_write) begin
        wcount++;
        if (first_write < 0) first_write = c;
      end
      if (last_done) begin
        wins.push_back(onehot_idx(last_grant));
        pkt_writes.push_back(wcount);
        wcount = 0;
        ndone++;
        if (ndone == 5) fifth_done = c;
      end
    end
    chk("contention_packets", ndone, 6);
    for (int k = 0; k < wins.size(); k++) begin
      chk("contention_order", wins[k], k % 5);
      chk("contention_writes", pkt_writes[k], FPP);
    end
`ifdef ARB_BACK_TO_BACK_EN
    chk("contention_span5", fifth_done - first_write + 1, 5 * FPP);
`else
    chk("contention_span5", fifth_done - first_write + 1, 5 * FPP + 4);
`endif

    // Backpressure for 3 cycles after the 4th write.
    do_reset();
    wr = 0; bp = 0; done_at = -1;
    for (int c = 0; c < 40 && done_at < 0; c++) begin
      df = (wr == 4 && bp < 3);
      step(5'b00010, 5'b00000, df, "backpressure");
      if (df) begin
        bp++;
        chk("bp_write_low", int'(last_write), 0);
        chk("bp_winner_stall", int'(last_stall[1]), 1);
      end
      if (last_write) wr++;
      if (last_done) done_at = c;
    end
    chk("bp_writes", wr, FPP);
    chk("bp_done_cycle", done_at, FPP + 3);

    // Winner's src_empty pulsed twice; a non-winner's bit toggles throughout.
    do_reset();
    wr = 0; done_at = -1;
    for (int c = 0; c < 40 && done_at < 0; c++) begin
      step(5'b00001, {1'b0, c[0], 2'b00, (c == 3 || c == 4)}, 1'b0, "src_empty");
      if (last_write) wr++;
      if (last_done) done_at = c;
    end
    chk("se_writes", wr, FPP);
    chk("se_done_cycle", done_at, FPP + 2);

    // Reset after the 5th write aborts the packet and restores the pointer.
    do_reset();
    wr = 0;
    for (int c = 0; c < 40 && wr < 5; c++) begin
      step(5'b01000, 5'b00000, 1'b0, "pre_reset");
      if (last_write) wr++;
    end
    chk("midrst_writes_before", wr, 5);
    request = 5'b10001;
    reset = 1'b1;
    #1;
    chk("midrst_grant", int'(grant), 0);
    chk("midrst_write", int'(write_fifo), 0);
    chk("midrst_stall", int'(stall_out), 5'b10001);
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    m_win = -1; m_left = 0; m_ptr = 0;
    step(5'b10001, 5'b00000, 1'b0, "post_reset");
    step(5'b10001, 5'b00000, 1'b0, "post_reset");
    chk("midrst_regrant_port0", int'(last_grant), 5'b00001);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      step(5'($urandom_range(0, 31)),
           ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'b00000,
           ($urandom_range(0, 4) == 0), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
